// File: rtl/psum_accum_pkg.sv
// Shared types and parameter defaults for the partial-sum accumulation engine.
package psum_accum_pkg;

    typedef enum logic [1:0] {
        MODE_PASS = 2'd0,
        MODE_ACC  = 2'd1,
        MODE_ADD  = 2'd2,
        MODE_RSVD = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam int LANES_DEF        = 4;
    localparam int DATA_W_DEF       = 16;
    localparam int PSUM_DEPTH_DEF   = 16;
    localparam int OUT_DEPTH_DEF    = 16;
    localparam int OUT_PAR_READ_DEF = 2;
    localparam int CNT_W_DEF        = 8;

endpackage

// File: rtl/Fifo_buffer.sv
// Circular FIFO with a RD_PAR-word parallel read port; oldest word in the lowest slice.
module Fifo_buffer #(
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 16,
    parameter int RD_PAR = 1
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    wen,
    input  logic [WIDTH-1:0]        din,
    input  logic                    ren,
    output logic [RD_PAR*WIDTH-1:0] dout,
    output logic                    empty,
    output logic                    full
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             do_wr;
    logic             do_rd;

    function automatic logic [AW-1:0] wrap_add(input logic [AW-1:0] p, input int k);
        int s;
        s = int'(p) + k;
        if (s >= DEPTH) s = s - DEPTH;
        return AW'(s);
    endfunction

    // "empty" means a full parallel read is not yet available
    assign empty = (count < CW'(RD_PAR));
    assign full  = (count == CW'(DEPTH));
    assign do_wr = wen && !full;
    assign do_rd = ren && !empty;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) wr_ptr <= wrap_add(wr_ptr, 1);
            if (do_rd) rd_ptr <= wrap_add(rd_ptr, RD_PAR);
            count <= count + (do_wr ? CW'(1) : CW'(0)) - (do_rd ? CW'(RD_PAR) : CW'(0));
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr] <= din;
    end

    always_comb begin
        dout = '0;
        if (!empty) begin
            for (int k = 0; k < RD_PAR; k++) begin
                dout[k*WIDTH +: WIDTH] = mem[wrap_add(rd_ptr, k)];
            end
        end
    end

endmodule

// File: rtl/psum_rr_arbiter.sv
// Round-robin arbiter: one-hot grant, search starts at the lane after the last grant.
module psum_rr_arbiter #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic [N-1:0] req,
    output logic [N-1:0] grant
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] ptr;
    int            grant_idx;

    always_comb begin
        logic found;
        int   idx;
        grant     = '0;
        grant_idx = 0;
        found     = 1'b0;
        idx       = 0;
        for (int k = 0; k < N; k++) begin
            idx = int'(ptr) + k;
            if (idx >= N) idx = idx - N;
            if (!found && req[idx]) begin
                found     = 1'b1;
                grant[idx] = 1'b1;
                grant_idx = idx;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ptr <= '0;
        end else if (|grant) begin
            ptr <= (grant_idx == N - 1) ? '0 : PW'(grant_idx + 1);
        end
    end

endmodule

// File: rtl/psum_accum_engine.sv
// Merges PE lane results (optionally with queued partial sums) into an output FIFO.
// Build option: PSUM_ACCUM_SAT_EN clamps mode-1 sums to DATA_W bits and sets sat_flag.
module psum_accum_engine
    import psum_accum_pkg::*;
#(
    parameter int LANES        = LANES_DEF,
    parameter int DATA_W       = DATA_W_DEF,
    parameter int PSUM_DEPTH   = PSUM_DEPTH_DEF,
    parameter int OUT_DEPTH    = OUT_DEPTH_DEF,
    parameter int OUT_PAR_READ = OUT_PAR_READ_DEF,
    parameter int CNT_W        = CNT_W_DEF
) (
    input  logic                               clk,
    input  logic                               rstn,
    input  logic                               start,
    input  logic [1:0]                         mode,
    input  logic [CNT_W-1:0]                   job_len,
    input  logic [LANES-1:0]                   lane_valid,
    input  logic [LANES*DATA_W-1:0]            lane_data,
    output logic [LANES-1:0]                   lane_ready,
    input  logic                               psum_wen,
    input  logic [DATA_W-1:0]                  psum_din,
    output logic                               psum_full,
    input  logic                               out_ren,
    output logic [OUT_PAR_READ*(DATA_W+1)-1:0] out_dout,
    output logic                               out_empty,
    output logic                               out_full,
    output logic                               busy,
    output logic                               done,
    output logic                               sat_flag,
    output state_e                             dbg_state
);

    state_e            state, state_nxt;
    mode_e             mode_q;
    logic [CNT_W-1:0]  len_q;
    logic [CNT_W-1:0]  cnt;

    logic [LANES-1:0]  req;
    logic [LANES-1:0]  grant;
    logic              granted;
    logic              add_pop;
    logic              consume;
    logic              psum_ren;
    logic              psum_empty;
    logic [DATA_W-1:0] psum_head;
    logic [DATA_W-1:0] sel_data;
    logic [DATA_W:0]   sum;
    logic [DATA_W:0]   out_word;
    logic              can_go;

    assign can_go = (state == ST_RUN) && !out_full;

    // Requests are only raised when the element can actually be consumed this cycle
    always_comb begin
        req     = '0;
        add_pop = 1'b0;
        case (mode_q)
            MODE_ACC: req     = (can_go && !psum_empty) ? lane_valid : '0;
            MODE_ADD: add_pop = can_go && !psum_empty;
            default:  req     = can_go ? lane_valid : '0;
        endcase
    end

    psum_rr_arbiter #(.N(LANES)) u_arb (
        .clk   (clk),
        .rstn  (rstn),
        .req   (req),
        .grant (grant)
    );

    assign lane_ready = grant;
    assign granted    = |grant;
    assign consume    = granted || add_pop;
    assign psum_ren   = (granted && (mode_q == MODE_ACC)) || add_pop;

    always_comb begin
        sel_data = '0;
        for (int i = 0; i < LANES; i++) begin
            if (grant[i]) sel_data = sel_data | lane_data[i*DATA_W +: DATA_W];
        end
    end

    assign sum = {1'b0, sel_data} + {1'b0, psum_head};

    always_comb begin
        out_word = {1'b0, sel_data};
        case (mode_q)
            MODE_ACC: out_word = sum;
            MODE_ADD: out_word = {1'b0, psum_head};
            default:  out_word = {1'b0, sel_data};
        endcase
`ifdef PSUM_ACCUM_SAT_EN
        if ((mode_q == MODE_ACC) && sum[DATA_W]) out_word = {1'b0, {DATA_W{1'b1}}};
`endif
    end

`ifdef PSUM_ACCUM_SAT_EN
    logic sat_q;
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sat_q <= 1'b0;
        end else if (granted && (mode_q == MODE_ACC) && sum[DATA_W]) begin
            sat_q <= 1'b1;
        end
    end
    assign sat_flag = sat_q;
`else
    assign sat_flag = 1'b0;
`endif

    Fifo_buffer #(.WIDTH(DATA_W), .DEPTH(PSUM_DEPTH), .RD_PAR(1)) u_psum_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .wen   (psum_wen),
        .din   (psum_din),
        .ren   (psum_ren),
        .dout  (psum_head),
        .empty (psum_empty),
        .full  (psum_full)
    );

    Fifo_buffer #(.WIDTH(DATA_W+1), .DEPTH(OUT_DEPTH), .RD_PAR(OUT_PAR_READ)) u_out_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .wen   (consume),
        .din   (out_word),
        .ren   (out_ren),
        .dout  (out_dout),
        .empty (out_empty),
        .full  (out_full)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (start) state_nxt = (job_len != '0) ? ST_RUN : ST_DONE;
            ST_RUN:  if (consume && (cnt == len_q - CNT_W'(1))) state_nxt = ST_DONE;
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state  <= ST_IDLE;
            mode_q <= MODE_PASS;
            len_q  <= '0;
            cnt    <= '0;
        end else begin
            state <= state_nxt;
            if ((state == ST_IDLE) && start) begin
                mode_q <= mode_e'(mode);
                len_q  <= job_len;
                cnt    <= '0;
            end else if ((state == ST_RUN) && consume) begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    assign busy      = (state == ST_RUN);
    assign done      = (state == ST_DONE);
    assign dbg_state = state;

endmodule

// File: tb/tb_psum_accum_engine.sv
// Directed self-checking bench for psum_accum_engine (default parameters).
module tb_psum_accum_engine;
    import psum_accum_pkg::*;

    localparam int LANES = 4;
    localparam int DW    = 16;
    localparam int PAR   = 2;
    localparam int OW    = DW + 1;

    logic                 clk;
    logic                 rstn;
    logic                 start;
    logic [1:0]           mode;
    logic [7:0]           job_len;
    logic [LANES-1:0]     lane_valid;
    logic [LANES*DW-1:0]  lane_data;
    logic [LANES-1:0]     lane_ready;
    logic                 psum_wen;
    logic [DW-1:0]        psum_din;
    logic                 psum_full;
    logic                 out_ren;
    logic [PAR*OW-1:0]    out_dout;
    logic                 out_empty;
    logic                 out_full;
    logic                 busy;
    logic                 done;
    logic                 sat_flag;
    state_e               dbg_state;

    int pass_cnt  = 0;
    int total_cnt = 0;
    logic [OW-1:0] exp_q[$];

    psum_accum_engine dut (
        .clk        (clk),
        .rstn       (rstn),
        .start      (start),
        .mode       (mode),
        .job_len    (job_len),
        .lane_valid (lane_valid),
        .lane_data  (lane_data),
        .lane_ready (lane_ready),
        .psum_wen   (psum_wen),
        .psum_din   (psum_din),
        .psum_full  (psum_full),
        .out_ren    (out_ren),
        .out_dout   (out_dout),
        .out_empty  (out_empty),
        .out_full   (out_full),
        .busy       (busy),
        .done       (done),
        .sat_flag   (sat_flag),
        .dbg_state  (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic start_job(input logic [1:0] m, input logic [7:0] len);
        mode    = m;
        job_len = len;
        start   = 1'b1;
        tick();
        start   = 1'b0;
    endtask

    task automatic push_psum(input logic [DW-1:0] v);
        psum_wen = 1'b1;
        psum_din = v;
        tick();
        psum_wen = 1'b0;
    endtask

    task automatic read_pair(input string tag);
        logic [PAR*OW-1:0] e;
        @(negedge clk);
        check({tag, "_empty"}, 64'(out_empty), 64'd0);
        if (exp_q.size() >= 2) begin
            e = {exp_q[1], exp_q[0]};
            void'(exp_q.pop_front());
            void'(exp_q.pop_front());
        end else begin
            e = '0;
        end
        check({tag, "_dout"}, 64'(out_dout), 64'(e));
        out_ren = 1'b1;
        tick();
        out_ren = 1'b0;
    endtask

    initial begin
        logic [LANES-1:0] exp_rdy;
        int               lane;

        rstn = 1'b0; start = 1'b0; mode = 2'd0; job_len = '0;
        lane_valid = '0; lane_data = '0; psum_wen = 1'b0; psum_din = '0; out_ren = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_lane_ready", 64'(lane_ready), 64'd0);
        check("rst_busy",       64'(busy),       64'd0);
        check("rst_done",       64'(done),       64'd0);
        check("rst_out_empty",  64'(out_empty),  64'd1);
        check("rst_out_full",   64'(out_full),   64'd0);
        check("rst_psum_full",  64'(psum_full),  64'd0);
        check("rst_out_dout",   64'(out_dout),   64'd0);
        check("rst_sat",        64'(sat_flag),   64'd0);
        rstn = 1'b1;
        tick();

        // Mode 0: four lanes, grants 0..3 in order
        start_job(2'd0, 8'd4);
        lane_valid = 4'hF;
        lane_data  = {16'd40, 16'd30, 16'd20, 16'd10};
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            exp_rdy = 4'd1 << k;
            check("m0_ready", 64'(lane_ready), 64'(exp_rdy));
            check("m0_busy",  64'(busy), 64'd1);
            tick();
        end
        exp_q.push_back(17'd10); exp_q.push_back(17'd20);
        exp_q.push_back(17'd30); exp_q.push_back(17'd40);
        @(negedge clk);
        check("m0_done",       64'(done),       64'd1);
        check("m0_done_ready", 64'(lane_ready), 64'd0);
        check("m0_done_busy",  64'(busy),       64'd0);
        lane_valid = '0;
        tick();
        check("m0_done_clear", 64'(done), 64'd0);
        read_pair("m0_rd0");
        read_pair("m0_rd1");
        @(negedge clk);
        check("m0_drained", 64'(out_empty), 64'd1);
        tick();

        // Zero-length job goes straight to DONE
        start_job(2'd0, 8'd0);
        @(negedge clk);
        check("z_done", 64'(done), 64'd1);
        check("z_busy", 64'(busy), 64'd0);
        tick();
        check("z_done_clear", 64'(done), 64'd0);

        // Mode 1: 0xFFFF + 0x0001 carries out, then 3 + 2
        push_psum(16'h0001);
        push_psum(16'h0002);
        lane_valid = 4'b0001;
        lane_data  = {48'd0, 16'hFFFF};
        start_job(2'd1, 8'd2);
        @(negedge clk);
        check("m1_ready0", 64'(lane_ready), 64'h1);
        tick();
        lane_data = {48'd0, 16'h0003};
        @(negedge clk);
        check("m1_ready1", 64'(lane_ready), 64'h1);
        tick();
`ifdef PSUM_ACCUM_SAT_EN
        exp_q.push_back(17'h0FFFF);
        check("m1_sat", 64'(sat_flag), 64'd1);
`else
        exp_q.push_back(17'h10000);
        check("m1_sat", 64'(sat_flag), 64'd0);
`endif
        exp_q.push_back(17'd5);
        check("m1_done", 64'(done), 64'd1);
        lane_valid = '0;
        tick();
        read_pair("m1_rd");

        // Mode 1 with empty psum FIFO: lanes must wait
        lane_valid = 4'b0110;
        lane_data  = {16'd0, 16'd200, 16'd100, 16'd0};
        start_job(2'd1, 8'd2);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("m1e_ready", 64'(lane_ready), 64'd0);
            check("m1e_empty", 64'(out_empty),  64'd1);
            tick();
        end
        psum_wen = 1'b1;
        psum_din = 16'd7;
        @(negedge clk);
        check("m1e_ready_wr", 64'(lane_ready), 64'd0);
        tick();
        psum_din = 16'd8;
        @(negedge clk);
        check("m1e_ready_l1", 64'(lane_ready), 64'b0010);
        tick();
        psum_wen = 1'b0;
        @(negedge clk);
        check("m1e_ready_l2", 64'(lane_ready), 64'b0100);
        tick();
        exp_q.push_back(17'd107);
        exp_q.push_back(17'd208);
        check("m1e_done", 64'(done), 64'd1);
        lane_valid = '0;
        tick();
        read_pair("m1e_rd");

        // Fill out FIFO: arbiter pointer now sits at lane 3
        lane_valid = 4'hF;
        lane_data  = {16'd4, 16'd3, 16'd2, 16'd1};
        start_job(2'd0, 8'd18);
        for (int g = 0; g < 16; g++) begin
            lane = (3 + g) % 4;
            @(negedge clk);
            exp_rdy = 4'd1 << lane;
            check("fill_ready", 64'(lane_ready), 64'(exp_rdy));
            exp_q.push_back(17'(lane + 1));
            tick();
        end
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            check("stall_ready", 64'(lane_ready), 64'd0);
            check("stall_full",  64'(out_full),   64'd1);
            check("stall_busy",  64'(busy),       64'd1);
            tick();
        end
        read_pair("stall_rd");
        for (int g = 16; g < 18; g++) begin
            lane = (3 + g) % 4;
            @(negedge clk);
            exp_rdy = 4'd1 << lane;
            check("resume_ready", 64'(lane_ready), 64'(exp_rdy));
            exp_q.push_back(17'(lane + 1));
            tick();
        end
        check("fill_done", 64'(done), 64'd1);
        lane_valid = '0;
        tick();
        for (int k = 0; k < 8; k++) read_pair("drain_rd");
        @(negedge clk);
        check("drain_empty", 64'(out_empty), 64'd1);
        tick();

        // Mode 2: psums pass through, lanes ignored
        push_psum(16'd5);
        push_psum(16'd6);
        push_psum(16'd7);
        lane_valid = 4'hF;
        start_job(2'd2, 8'd3);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("m2_ready", 64'(lane_ready), 64'd0);
            tick();
        end
        exp_q.push_back(17'd5); exp_q.push_back(17'd6); exp_q.push_back(17'd7);
        check("m2_done", 64'(done), 64'd1);
        lane_valid = '0;
        tick();
        read_pair("m2_rd");

        // Reset in the middle of a mode 2 job
        push_psum(16'd9);
        start_job(2'd2, 8'd3);
        @(negedge clk);
        check("mid_busy", 64'(busy), 64'd1);
        tick();
        rstn = 1'b0;
        #1;
        check("mrst_busy",      64'(busy),       64'd0);
        check("mrst_out_empty", 64'(out_empty),  64'd1);
        check("mrst_out_dout",  64'(out_dout),   64'd0);
        check("mrst_done",      64'(done),       64'd0);
        check("mrst_ready",     64'(lane_ready), 64'd0);
        exp_q.delete();
        tick();
        rstn = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("post_rst_done", 64'(done), 64'd0);
            check("post_rst_busy", 64'(busy), 64'd0);
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/psum_accum_engine.md
PSUM_ACCUM_ENGINE -- requirements
Module: psum_accum_engine

Interface
REQ-001 Parameter LANES, default 4: number of parallel PE result lanes.
REQ-002 Parameter DATA_W, default 16: lane result and input psum width.
REQ-003 Parameter PSUM_DEPTH, default 16: input psum FIFO entries.
REQ-004 Parameter OUT_DEPTH, default 16: output FIFO entries.
REQ-005 Parameter OUT_PAR_READ, default 2: words popped per output read.
REQ-006 Parameter CNT_W, default 8: job length counter width.
REQ-007 Port clk, in, 1: single clock; all state on rising edge.
REQ-008 Port rstn, in, 1: asynchronous active-low reset.
REQ-009 Port start, in, 1: job start pulse.
REQ-010 Port mode, in, 2: 0 pass, 1 accumulate, 2 just-add, 3 reserved.
REQ-011 Port job_len, in, CNT_W: elements per job.
REQ-012 Ports lane_valid in LANES / lane_data in LANES*DATA_W / lane_ready out LANES: per-lane valid-ready; lane i in slice i.
REQ-013 Ports psum_wen in 1 / psum_din in DATA_W / psum_full out 1: input psum FIFO write side.
REQ-014 Ports out_ren in 1 / out_dout out OUT_PAR_READ*(DATA_W+1) / out_empty out 1 / out_full out 1: output FIFO read side, oldest word in lowest slice.
REQ-015 Ports busy, done, sat_flag, out, 1 each: job active, one-cycle completion pulse, sticky saturation.

Function
REQ-016 FSM states IDLE, RUN, DONE; IDLE->RUN on start with job_len!=0; start with job_len==0 goes IDLE->DONE.
REQ-017 mode and job_len are sampled on accepted start; changes during RUN have no effect; start during RUN/DONE is ignored.
REQ-018 In RUN, at most one element is consumed per cycle; RUN->DONE in the cycle the element count reaches job_len; DONE lasts one cycle with done=1, then IDLE.
REQ-019 Modes 0/3: round-robin arbiter grants one lane with lane_valid=1, search starting at lane after last grant; lane_ready[g] asserted combinationally in grant cycle; written word = {1'b0, lane_data[g]}.
REQ-020 Mode 1: grant additionally requires psum FIFO non-empty; granted lane and head psum pop together; written word = lane_data[g] + psum, DATA_W+1 bits, carry kept.
REQ-021 Mode 2: lanes ignored (lane_ready=0); each cycle with psum non-empty pops one psum and writes {1'b0, psum}.
REQ-022 No grant or pop while out FIFO full; consumed element written to out FIFO in the same edge, readable next cycle (latency 1).
REQ-023 lane_ready is 0 outside RUN; busy=1 in RUN only.
REQ-024 psum_wen while psum_full is dropped; psum writes accepted in every state.
REQ-025 out_empty=1 while fewer than OUT_PAR_READ words stored; out_ren with out_empty=1 ignored; simultaneous read and write on out FIFO both take effect.
REQ-026 Arbiter pointer persists across jobs; cleared only by reset.

Reset
REQ-027 rstn low: FSM IDLE, counters 0, arbiter pointer to lane 0, both FIFOs emptied, sat_flag 0.
REQ-028 Output values under reset: lane_ready 0, busy 0, done 0, out_empty 1, out_full 0, psum_full 0, out_dout 0.
REQ-029 Reset mid-job aborts with no done pulse; partial results are discarded.

Configuration
REQ-030 Macro PSUM_ACCUM_SAT_EN defined: mode 1 sums exceeding 2^DATA_W-1 are clamped to {1'b0, all ones} and set sat_flag until reset.
REQ-031 Macro undefined: full DATA_W+1 sum stored, sat_flag tied 0.

Structure
REQ-032 Package psum_accum_pkg holds the mode encoding, FSM state type and parameter defaults.
REQ-033 Sub-module psum_rr_arbiter (LANES-wide request, one-hot grant, pointer update on grant); both FIFOs are instances of the existing Fifo_buffer.

Verification
REQ-034 Mode 0, job_len=4, all lanes valid data 10,20,30,40 -> grants lanes 0,1,2,3 in four cycles, out words 10,20,30,40, done one cycle later.
REQ-035 Mode 1, lane 0 data 0xFFFF, psum 0x0001 -> out word 0x10000 (macro off) or 0x0FFFF with sat_flag=1 (macro on).
REQ-036 Mode 1, psum FIFO empty for 3 cycles with lanes valid -> no lane_ready, no out write until first psum_wen.
REQ-037 Fill out FIFO to OUT_DEPTH, out_ren low -> arbiter stalls; one out_ren with OUT_PAR_READ=2 -> 2 oldest words returned, stalled grants resume.
REQ-038 Mode 2, job_len=3, psum 5,6,7 -> out words 5,6,7, lane_ready stays 0; rstn low mid-job -> busy 0, out_empty 1, no done.
